gmii_rx_deframer: RTL and testbench
===================================

Name: gmii_rx_deframer

Overview:
- Consumes the byte-wide GMII RX bus produced by the RGMII-to-GMII bridge, in the gmii_rxc domain.
- Strips preamble and SFD, checks the CRC-32 FCS, and enforces length limits.
- Emits the frame body without FCS to the MAC RX FIFO as a byte stream.
- Signals commit or drop at end of frame, so the downstream FIFO can roll back bad frames.

Parameters:
MAX_FRAME  1522  maximum legal frame length in bytes, including FCS
MIN_FRAME  64  minimum legal frame length in bytes, including FCS

Ports:
gmii_rxc  in  1  RX clock; all logic is in this single domain
rst  in  1  asynchronous, active-high reset
gmii_rx_en  in  1  GMII frame-active flag
gmii_rx_er  in  1  GMII error flag, qualified by en
gmii_rx_dvalid  in  1  data byte valid this cycle; toggles in 10/100 mode
gmii_rx_data  in  8  GMII RX byte
link_up  in  1  PHY in-band link status
rx_frame_start  out  1  one-cycle pulse, registered, coincident with the first rx_frame_valid of a frame
rx_frame_valid  out  1  rx_frame_data carries a body byte
rx_frame_data  out  8  frame body byte (destination MAC first)
rx_frame_commit  out  1  one-cycle pulse: frame good
rx_frame_drop  out  1  one-cycle pulse: discard everything since rx_frame_start
crc_err_count  out  16  saturating count of FCS failures
len_err_count  out  16  saturating count of runt and giant frames

Behaviour:
- Reset: all outputs 0, state IDLE, delay line empty, byte count 0, CRC register 0xFFFFFFFF.
- Only cycles with en=1 and dvalid=1 are "beats". Cycles with dvalid=0 hold all state and assert no valid output.
- States:
  - IDLE: on a beat with data 0x55 -> PREAMBLE. On a beat with data 0xD5 -> FRAME, accepting an SFD with no preamble. On any other beat -> DROP.
  - PREAMBLE: beat 0x55 -> stay. Beat 0xD5 -> FRAME; clear CRC to 0xFFFFFFFF, count to 0, delay line to empty. Other beat -> DROP. en falls -> IDLE, with no pulse.
  - FRAME: each beat updates the CRC and increments the count, which saturates at MAX_FRAME+1. Each beat also shifts into the 4-entry delay line.
    - Once the delay line holds 4 bytes, each beat emits the oldest byte next cycle: rx_frame_valid=1, rx_frame_data = that byte.
    - The first emitted byte also pulses rx_frame_start. Effective latency is 4 beats plus 1 register stage.
    - The FCS bytes remaining in the line are never emitted.
  - DROP: ignore input until en=0, then -> IDLE. A drop in DROP entered from IDLE/PREAMBLE produces no pulse.
- CRC: reflected CRC-32, polynomial 0x04C11DB7 (reflected 0xEDB88320), LSB-first, init 0xFFFFFFFF, computed over body plus FCS. The frame is good iff the final register equals 0xDEBB20E3.
- End of frame (first cycle en=0 while in FRAME): next cycle pulse exactly one of commit or drop, then -> IDLE. Drop if any of:
  - er seen while en=1 in FRAME;
  - count < MIN_FRAME;
  - count > MAX_FRAME;
  - CRC residue wrong;
  - link_up=0 at any point in FRAME.
- If start was never pulsed (count <= 4), the end-of-frame pulse is still drop, since the frame is a runt.
- Error precedence in FRAME:
  - er mid-frame -> DROP immediately, one-cycle drop pulse next cycle, no further valid bytes.
  - Count exceeding MAX_FRAME -> same immediate drop. len_err_count increments.
- Counters:
  - crc_err_count increments when the drop reason is CRC only (length legal, no er).
  - len_err_count increments on runt or giant.
  - Both saturate at 0xFFFF and are cleared only by reset.
- commit and drop are never asserted together. No rx_frame_valid occurs in the same cycle as or after commit/drop for that frame.
- Back-to-back frames: en low for a single cycle is sufficient. IDLE accepts a new preamble on the cycle after the end-of-frame pulse.
- Reset asserted mid-frame: outputs clear immediately, no commit/drop pulse. After release, the block waits in IDLE and drops any partial frame still on the wire, because its first byte is not 0x55/0xD5.

Test Plan:
- 1000M, dvalid=1 always: 7x0x55, 0xD5, 60-byte body 0x00..0x3B plus correct FCS -> 60 valid bytes 0x00..0x3B; start pulses with byte 0x00, 5 cycles after the first body beat; commit 1 cycle after en falls.
- 10/100 pattern, dvalid alternating 1/0, same frame -> identical byte sequence, valid only on beats, commit once.
- Same frame with FCS LSB flipped -> all 60 bytes emitted, then drop; crc_err_count=1, len_err_count=0.
- er asserted on body byte 20 -> bytes 0..15 emitted, drop next cycle, no further valid even though the frame continues to byte 63.
- 40-byte frame with valid FCS -> drop, len_err_count=1; 1600-byte frame with MAX_FRAME=1522 -> drop pulse one cycle after beat 1523, len_err_count=2.
- Assert rst at body byte 30, release 3 cycles later with the frame continuing -> no commit/drop for that frame; next clean frame commits normally.

Source files
------------

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, verifies the CRC-32 FCS and frame length,
// and streams the frame body with a commit/drop verdict at end of frame.
module gmii_rx_deframer #(
   parameter int unsigned MAX_FRAME = 1522,
   parameter int unsigned MIN_FRAME = 64
) (
   input  logic        gmii_rxc,
   input  logic        rst,
   input  logic        gmii_rx_en,
   input  logic        gmii_rx_er,
   input  logic        gmii_rx_dvalid,
   input  logic [7:0]  gmii_rx_data,
   input  logic        link_up,
   output logic        rx_frame_start,
   output logic        rx_frame_valid,
   output logic [7:0]  rx_frame_data,
   output logic        rx_frame_commit,
   output logic        rx_frame_drop,
   output logic [15:0] crc_err_count,
   output logic [15:0] len_err_count
);

   localparam int unsigned CW = $clog2(MAX_FRAME + 2);
   localparam logic [CW-1:0] MaxLen = CW'(MAX_FRAME);
   localparam logic [CW-1:0] MinLen = CW'(MIN_FRAME);
   localparam logic [CW-1:0] MaxSat = CW'(MAX_FRAME + 1);
   localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

   typedef enum logic [1:0] {StIdle, StPreamble, StFrame, StDrop} state_e;

   state_e state_q, state_d;

   logic [31:0]     crc_q, crc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [3:0][7:0] dline_q, dline_d;
   logic [2:0]      fill_q, fill_d;
   logic            started_q, started_d;
   logic            link_lost_q, link_lost_d;
   logic            valid_q, valid_d;
   logic [7:0]      data_q, data_d;
   logic            start_q, start_d;
   logic            commit_q, commit_d;
   logic            drop_q, drop_d;
   logic [15:0]     crc_err_q, crc_err_d;
   logic [15:0]     len_err_q, len_err_d;

   logic          beat, is_pre, is_sfd, er_hit, giant, len_ok, crc_ok;
   logic [CW-1:0] count_inc;

   // Reflected CRC-32, one byte LSB-first
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   assign beat      = gmii_rx_en & gmii_rx_dvalid;
   assign is_pre    = (gmii_rx_data == 8'h55);
   assign is_sfd    = (gmii_rx_data == 8'hD5);
   assign er_hit    = gmii_rx_en & gmii_rx_er;
   assign count_inc = (count_q == MaxSat) ? count_q : count_q + CW'(1);
   assign giant     = beat & (count_inc > MaxLen);
   assign len_ok    = (count_q >= MinLen) && (count_q <= MaxLen);
   assign crc_ok    = (crc_q == CrcResidue);

   always_ff @(posedge gmii_rxc or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (beat) state_d = is_pre ? StPreamble : (is_sfd ? StFrame : StDrop);
         end
         StPreamble: begin
            if (!gmii_rx_en) state_d = StIdle;
            else if (beat)   state_d = is_pre ? StPreamble : (is_sfd ? StFrame : StDrop);
         end
         StFrame: begin
            if (!gmii_rx_en)          state_d = StIdle;
            else if (er_hit || giant) state_d = StDrop;
         end
         StDrop: begin
            if (!gmii_rx_en) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      crc_d       = crc_q;
      count_d     = count_q;
      dline_d     = dline_q;
      fill_d      = fill_q;
      started_d   = started_q;
      link_lost_d = link_lost_q;
      data_d      = data_q;
      crc_err_d   = crc_err_q;
      len_err_d   = len_err_q;
      valid_d     = 1'b0;
      start_d     = 1'b0;
      commit_d    = 1'b0;
      drop_d      = 1'b0;

      if ((state_q == StIdle || state_q == StPreamble) && beat && is_sfd) begin
         crc_d       = 32'hFFFF_FFFF;
         count_d     = '0;
         fill_d      = '0;
         started_d   = 1'b0;
         link_lost_d = 1'b0;
      end

      if (state_q == StFrame) begin
         link_lost_d = link_lost_q | ~link_up;
         if (!gmii_rx_en) begin
            if (len_ok && crc_ok && !link_lost_d) begin
               commit_d = 1'b1;
            end else begin
               drop_d = 1'b1;
               if (!len_ok) begin
                  len_err_d = (len_err_q == 16'hFFFF) ? len_err_q : len_err_q + 16'd1;
               end else if (!crc_ok) begin
                  crc_err_d = (crc_err_q == 16'hFFFF) ? crc_err_q : crc_err_q + 16'd1;
               end
            end
         end else if (er_hit) begin
            drop_d = 1'b1;
         end else if (beat) begin
            crc_d   = crc_byte(crc_q, gmii_rx_data);
            count_d = count_inc;
            if (giant) begin
               drop_d    = 1'b1;
               len_err_d = (len_err_q == 16'hFFFF) ? len_err_q : len_err_q + 16'd1;
            end else begin
               // Four-byte holdback keeps the FCS from ever reaching the output
               dline_d = {dline_q[2:0], gmii_rx_data};
               if (fill_q == 3'd4) begin
                  valid_d   = 1'b1;
                  data_d    = dline_q[3];
                  start_d   = ~started_q;
                  started_d = 1'b1;
               end else begin
                  fill_d = fill_q + 3'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge gmii_rxc or posedge rst) begin
      if (rst) begin
         crc_q       <= 32'hFFFF_FFFF;
         count_q     <= '0;
         dline_q     <= '0;
         fill_q      <= '0;
         started_q   <= 1'b0;
         link_lost_q <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         start_q     <= 1'b0;
         commit_q    <= 1'b0;
         drop_q      <= 1'b0;
         crc_err_q   <= '0;
         len_err_q   <= '0;
      end else begin
         crc_q       <= crc_d;
         count_q     <= count_d;
         dline_q     <= dline_d;
         fill_q      <= fill_d;
         started_q   <= started_d;
         link_lost_q <= link_lost_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         start_q     <= start_d;
         commit_q    <= commit_d;
         drop_q      <= drop_d;
         crc_err_q   <= crc_err_d;
         len_err_q   <= len_err_d;
      end
   end

   assign rx_frame_start  = start_q;
   assign rx_frame_valid  = valid_q;
   assign rx_frame_data   = data_q;
   assign rx_frame_commit = commit_q;
   assign rx_frame_drop   = drop_q;
   assign crc_err_count   = crc_err_q;
   assign len_err_count   = len_err_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed bench for gmii_rx_deframer: a frame-level model predicts the output event stream
// (body bytes, then commit or drop) and a compare process checks every active output cycle.
module tb_gmii_rx_deframer;

   localparam int MaxFrame = 1522;
   localparam int MinFrame = 64;
   localparam logic [11:0] EvCommit = 12'h200;
   localparam logic [11:0] EvDrop   = 12'h100;

   logic        gmii_rxc = 1'b0;
   logic        rst;
   logic        gmii_rx_en;
   logic        gmii_rx_er;
   logic        gmii_rx_dvalid;
   logic [7:0]  gmii_rx_data;
   logic        link_up;
   logic        rx_frame_start;
   logic        rx_frame_valid;
   logic [7:0]  rx_frame_data;
   logic        rx_frame_commit;
   logic        rx_frame_drop;
   logic [15:0] crc_err_count;
   logic [15:0] len_err_count;

   gmii_rx_deframer #(
      .MAX_FRAME(MaxFrame),
      .MIN_FRAME(MinFrame)
   ) dut (
      .gmii_rxc        (gmii_rxc),
      .rst             (rst),
      .gmii_rx_en      (gmii_rx_en),
      .gmii_rx_er      (gmii_rx_er),
      .gmii_rx_dvalid  (gmii_rx_dvalid),
      .gmii_rx_data    (gmii_rx_data),
      .link_up         (link_up),
      .rx_frame_start  (rx_frame_start),
      .rx_frame_valid  (rx_frame_valid),
      .rx_frame_data   (rx_frame_data),
      .rx_frame_commit (rx_frame_commit),
      .rx_frame_drop   (rx_frame_drop),
      .crc_err_count   (crc_err_count),
      .len_err_count   (len_err_count)
   );

   always #5 gmii_rxc = ~gmii_rxc;

   int cyc = 0;
   always @(posedge gmii_rxc) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   int n_valid = 0;
   int start_cyc = 0;
   int end_cyc = 0;
   int body_cyc = 0;
   int eof_cyc = 0;
   int giant_cyc = 0;
   logic [11:0] exp_q[$];
   logic [7:0]  frame_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // FCS value (complemented CRC) over the first n bytes of frame_q, computed bit-serially
   function automatic logic [31:0] crc32_body(input int n);
      logic [31:0] c;
      logic        fbk;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++) begin
            fbk = c[0] ^ frame_q[i][b];
            c   = c >> 1;
            if (fbk) c = c ^ 32'hEDB88320;
         end
      end
      return ~c;
   endfunction

   // Expected output events for the frame in frame_q (body followed by 4 FCS bytes)
   task automatic model_frame(input int n_body, input int er_at, input int rst_at);
      int   n;
      int   k;
      logic good;
      n = frame_q.size();
      if (rst_at >= 0)      k = rst_at - 5;
      else if (er_at >= 0)  k = (er_at > 4) ? er_at - 4 : 0;
      else if (n > MaxFrame) k = MaxFrame - 4;
      else                  k = (n > 4) ? n - 4 : 0;
      for (int j = 0; j < k; j++) exp_q.push_back({1'b1, (j == 0), 2'b00, frame_q[j]});
      if (rst_at >= 0) return;
      if (er_at >= 0 || n > MaxFrame) begin
         exp_q.push_back(EvDrop);
      end else begin
         good = (n >= MinFrame) &&
                ({frame_q[n_body+3], frame_q[n_body+2], frame_q[n_body+1], frame_q[n_body]}
                 == crc32_body(n_body));
         exp_q.push_back(good ? EvCommit : EvDrop);
      end
   endtask

   task automatic compare_loop();
      logic [11:0] act;
      logic [11:0] e;
      forever begin
         @(negedge gmii_rxc);
         if (!rst) begin
            act = {rx_frame_valid, rx_frame_start, rx_frame_commit, rx_frame_drop,
                   rx_frame_valid ? rx_frame_data : 8'h00};
            if (act[11:8] != 4'b0000) begin
               e = (exp_q.size() == 0) ? 12'h000 : exp_q.pop_front();
               check("stream", {20'h0, act}, {20'h0, e});
               if (rx_frame_valid) n_valid++;
               if (rx_frame_start) start_cyc = cyc;
               if (rx_frame_commit || rx_frame_drop) end_cyc = cyc;
            end
         end
      end
   endtask

   task automatic drive(input logic en, input logic er, input logic [7:0] d, input bit slow);
      gmii_rx_en     = en;
      gmii_rx_er     = er;
      gmii_rx_data   = d;
      gmii_rx_dvalid = 1'b1;
      @(posedge gmii_rxc);
      #1;
      if (slow) begin
         gmii_rx_er     = 1'b0;
         gmii_rx_dvalid = 1'b0;
         @(posedge gmii_rxc);
         #1;
      end
   endtask

   task automatic send_frame(input int n_body, input bit bad_fcs, input int er_at, input bit slow,
                             input int rst_at, input int gap);
      logic [31:0] fcs;
      frame_q.delete();
      for (int i = 0; i < n_body; i++) frame_q.push_back(8'(i));
      fcs = crc32_body(n_body);
      frame_q.push_back(fcs[7:0]);
      frame_q.push_back(fcs[15:8]);
      frame_q.push_back(fcs[23:16]);
      frame_q.push_back(fcs[31:24]);
      if (bad_fcs) frame_q[n_body] = frame_q[n_body] ^ 8'h01;
      model_frame(n_body, er_at, rst_at);
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, slow);
      drive(1'b1, 1'b0, 8'hD5, slow);
      for (int i = 0; i < frame_q.size(); i++) begin
         if (i == 0) body_cyc = cyc;
         if (i == MaxFrame) giant_cyc = cyc;
         rst = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + 3);
         drive(1'b1, (i == er_at), frame_q[i], slow);
      end
      rst = 1'b0;
      eof_cyc = cyc;
      for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int v0;
      rst            = 1'b1;
      gmii_rx_en     = 1'b0;
      gmii_rx_er     = 1'b0;
      gmii_rx_dvalid = 1'b0;
      gmii_rx_data   = 8'h00;
      link_up        = 1'b1;
      fork
         compare_loop();
      join_none

      // Pin the bench CRC with the standard check value of "123456789"
      frame_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      check("crc_pin", crc32_body(9), 32'hCBF43926);

      repeat (3) @(posedge gmii_rxc);
      @(negedge gmii_rxc);
      check("rst_flags", {28'h0, rx_frame_valid, rx_frame_start, rx_frame_commit, rx_frame_drop},
            32'h0);
      check("rst_data", {24'h0, rx_frame_data}, 32'h0);
      check("rst_counters", {crc_err_count, len_err_count}, 32'h0);
      @(posedge gmii_rxc);
      #1;
      rst = 1'b0;
      repeat (2) begin
         @(posedge gmii_rxc);
         #1;
      end

      // Gigabit clean 64-byte frame
      v0 = n_valid;
      send_frame(60, 1'b0, -1, 1'b0, -1, 3);
      check("t1_count", 32'(n_valid - v0), 32'd60);
      check("t1_start_latency", 32'(start_cyc - body_cyc), 32'd5);
      check("t1_commit_latency", 32'(end_cyc - eof_cyc), 32'd1);
      check("t1_drain", 32'(exp_q.size()), 32'd0);
      check("t1_counters", {crc_err_count, len_err_count}, 32'h0);

      // 10/100 pacing, dvalid toggling
      v0 = n_valid;
      send_frame(60, 1'b0, -1, 1'b1, -1, 3);
      check("t2_count", 32'(n_valid - v0), 32'd60);
      check("t2_drain", 32'(exp_q.size()), 32'd0);

      // Corrupted FCS
      v0 = n_valid;
      send_frame(60, 1'b1, -1, 1'b0, -1, 3);
      check("t3_count", 32'(n_valid - v0), 32'd60);
      check("t3_drain", 32'(exp_q.size()), 32'd0);
      check("t3_counters", {crc_err_count, len_err_count}, {16'd1, 16'd0});

      // er on body byte 20
      v0 = n_valid;
      send_frame(60, 1'b0, 20, 1'b0, -1, 3);
      check("t4_count", 32'(n_valid - v0), 32'd16);
      check("t4_drain", 32'(exp_q.size()), 32'd0);
      check("t4_counters", {crc_err_count, len_err_count}, {16'd1, 16'd0});

      // 40-byte runt with valid FCS
      send_frame(36, 1'b0, -1, 1'b0, -1, 3);
      check("t5_drain", 32'(exp_q.size()), 32'd0);
      check("t5_counters", {crc_err_count, len_err_count}, {16'd1, 16'd1});

      // 1600-byte giant
      v0 = n_valid;
      send_frame(1596, 1'b0, -1, 1'b0, -1, 3);
      check("t6_count", 32'(n_valid - v0), 32'd1518);
      check("t6_drop_latency", 32'(end_cyc - giant_cyc), 32'd1);
      check("t6_drain", 32'(exp_q.size()), 32'd0);
      check("t6_counters", {crc_err_count, len_err_count}, {16'd1, 16'd2});

      // Back-to-back frames with a single idle cycle between them
      v0 = n_valid;
      send_frame(60, 1'b0, -1, 1'b0, -1, 1);
      send_frame(60, 1'b0, -1, 1'b0, -1, 3);
      check("t7_count", 32'(n_valid - v0), 32'd120);
      check("t7_drain", 32'(exp_q.size()), 32'd0);

      // Reset mid-frame, then a clean frame
      v0 = n_valid;
      send_frame(60, 1'b0, -1, 1'b0, 30, 3);
      check("t8_count", 32'(n_valid - v0), 32'd25);
      check("t8_drain", 32'(exp_q.size()), 32'd0);
      check("t8_counters", {crc_err_count, len_err_count}, 32'h0);
      v0 = n_valid;
      send_frame(60, 1'b0, -1, 1'b0, -1, 3);
      check("t9_count", 32'(n_valid - v0), 32'd60);
      check("t9_commit_latency", 32'(end_cyc - eof_cyc), 32'd1);
      check("t9_drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
